// File: rtl/bp_reset_release_sequencer.sv
// Purpose: turns the raw async active-low board reset into ordered, synchronous,
//          active-high per-domain resets released one at a time on a ready handshake.
// Latency: domain 0 leaves reset sync_stages_p + hold_cycles_p + 2 clk after reset rises.
// Backpressure: each release waits on dom_ready_i of the previous domain, with a timeout.
module bp_reset_release_sequencer #(
   parameter int sync_stages_p = 2,
   parameter int num_domains_p = 3,
   parameter int hold_cycles_p = 20,
   parameter int gap_cycles_p  = 4,
   parameter int timeout_p     = 1024,
   // Derived widths; not meant to be overridden.
   parameter int idx_width_p   = (num_domains_p > 1) ? $clog2(num_domains_p) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     soft_reset_req_i,
   input  logic [num_domains_p-1:0] dom_ready_i,
   output logic [num_domains_p-1:0] dom_reset_o,
   output logic                     assert_en_o,
   output logic                     done_o,
   output logic                     error_o,
   output logic [idx_width_p-1:0]   err_domain_o
);

   // One shared counter serves the hold, gap and timeout phases, so it is sized
   // for the longest of the three; it never counts past the active terminal value.
   localparam int HG_MAX  = (hold_cycles_p > gap_cycles_p) ? hold_cycles_p : gap_cycles_p;
   localparam int CNT_MAX = (HG_MAX > timeout_p) ? HG_MAX : timeout_p;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam int HOLD_LAST = hold_cycles_p - 1;
   localparam int GAP_LAST  = (gap_cycles_p > 0) ? gap_cycles_p - 1 : 0;
   localparam int TO_LAST   = timeout_p - 1;
   localparam int DOM_LAST  = num_domains_p - 1;

   typedef enum logic [2:0] {
      ST_SYNC  = 3'd0,
      ST_HOLD  = 3'd1,
      ST_REL   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERROR = 3'd6
   } state_t;

   logic [sync_stages_p-1:0] sync_q;
   logic                     rst_sync;

   state_t                   state_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [idx_width_p-1:0]   idx_q;
   logic [num_domains_p-1:0] dom_reset_q;
   logic                     assert_en_q;
   logic                     done_q;
   logic                     error_q;
   logic [idx_width_p-1:0]   err_domain_q;

   // Reset-deassertion synchronizer: cleared asynchronously, a 1 walks in on clk.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[sync_stages_p-2:0], 1'b1};
      end
   end

   assign rst_sync = sync_q[sync_stages_p-1];

   // Release sequencer: state, shared counter, domain index and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_SYNC;
         cnt_q        <= '0;
         idx_q        <= '0;
         dom_reset_q  <= '1;
         assert_en_q  <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         err_domain_q <= '0;
      end else if (soft_reset_req_i && (state_q != ST_SYNC)) begin
         // Soft reset re-enters HOLD directly; the synchronizer is already settled.
         state_q     <= ST_HOLD;
         cnt_q       <= '0;
         idx_q       <= '0;
         dom_reset_q <= '1;
         assert_en_q <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_SYNC: begin
               cnt_q <= '0;
               if (rst_sync) begin
                  state_q <= ST_HOLD;
               end
            end

            ST_HOLD: begin
               if (cnt_q == CNT_W'(HOLD_LAST)) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  state_q <= ST_REL;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            ST_REL: begin
               dom_reset_q[idx_q] <= 1'b0;
               cnt_q              <= '0;
               state_q            <= ST_WAIT;
            end

            ST_WAIT: begin
               // Ready is checked before the timeout so a same-cycle ready wins.
               if (dom_ready_i[idx_q]) begin
                  cnt_q <= '0;
                  if (idx_q == idx_width_p'(DOM_LAST)) begin
                     state_q     <= ST_DONE;
                     done_q      <= 1'b1;
                     assert_en_q <= 1'b1;
                  end else if (gap_cycles_p == 0) begin
                     // No gap requested: next release follows immediately,
                     // giving back-to-back two-cycle release spacing.
                     idx_q   <= idx_q + idx_width_p'(1);
                     state_q <= ST_REL;
                  end else begin
                     state_q <= ST_GAP;
                  end
               end else if (cnt_q == CNT_W'(TO_LAST)) begin
                  state_q      <= ST_ERROR;
                  error_q      <= 1'b1;
                  err_domain_q <= idx_q;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            ST_GAP: begin
               if (cnt_q == CNT_W'(GAP_LAST)) begin
                  cnt_q   <= '0;
                  idx_q   <= idx_q + idx_width_p'(1);
                  state_q <= ST_REL;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            // DONE and ERROR are terminal until a soft reset or reset low.
            ST_DONE:  state_q <= ST_DONE;
            ST_ERROR: state_q <= ST_ERROR;

            default: begin
               state_q     <= ST_SYNC;
               cnt_q       <= '0;
               dom_reset_q <= '1;
            end
         endcase
      end
   end

   assign dom_reset_o  = dom_reset_q;
   assign assert_en_o  = assert_en_q;
   assign done_o       = done_q;
   assign error_o      = error_q;
   assign err_domain_o = err_domain_q;

endmodule
